// File: rtl/fft2d_row_col_sched.sv
// Row-column 2D FFT sequencer: buffers one NxN frame and runs rows then columns through a shared 1D core.
// Optional FFT2D_INVERSE_EN adds an inverse port that selects IFFT in the core config word.
module fft2d_row_col_sched #(
    parameter int N  = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef FFT2D_INVERSE_EN
    input  logic          inverse,
`endif
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          fft_aresetn,
    output logic [7:0]    fft_cfg_tdata,
    output logic          fft_cfg_tvalid,
    input  logic          fft_cfg_tready,
    output logic [DW-1:0] fft_s_tdata,
    output logic          fft_s_tvalid,
    input  logic          fft_s_tready,
    output logic          fft_s_tlast,
    input  logic [DW-1:0] fft_m_tdata,
    input  logic          fft_m_tvalid,
    output logic          fft_m_tready,
    input  logic          fft_m_tlast
);
    localparam int L  = $clog2(N);
    localparam int NN = N * N;

    typedef enum logic [3:0] {
        RST_HOLD, IDLE, LOAD, CFG, ROW_SEND, ROW_RECV, COL_SEND, COL_RECV, UNLOAD, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [L-1:0]     line_q, line_d, beat_q, beat_d;
    logic [2*L-1:0]   idx_q, idx_d;
    logic [1:0]       hold_q, hold_d;
    logic             err_q, err_d, inv_q, inv_d;
    logic             busy_q, done_q, in_ready_q, out_valid_q, out_last_q;
    logic             aresetn_q, cfg_valid_q, s_valid_q, s_last_q, m_ready_q;
    logic [DW-1:0]    buf_q [NN];
    logic             wr_en;
    logic [2*L-1:0]   wr_addr, line_addr;
    logic [DW-1:0]    wr_data;
    logic             in_fire, cfg_fire, s_fire, m_fire, out_fire, row_phase;
    logic             send_d, recv_d;

    assign in_fire   = in_valid && in_ready_q;
    assign cfg_fire  = cfg_valid_q && fft_cfg_tready;
    assign s_fire    = s_valid_q && fft_s_tready;
    assign m_fire    = fft_m_tvalid && m_ready_q;
    assign out_fire  = out_valid_q && out_ready;
    assign row_phase = (state_q == ROW_SEND) || (state_q == ROW_RECV);
    // Rows walk {line, beat}; columns transpose the same counters.
    assign line_addr = row_phase ? {line_q, beat_q} : {beat_q, line_q};

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        err_d   = err_q;
        inv_d   = inv_q;
        wr_en   = 1'b0;
        wr_addr = line_addr;
        wr_data = fft_m_tdata;
        case (state_q)
            RST_HOLD: begin
                hold_d = hold_q + 2'd1;
                if (&hold_q) state_d = IDLE;
            end
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
`ifdef FFT2D_INVERSE_EN
                    inv_d   = inverse;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    wr_en   = 1'b1;
                    wr_addr = idx_q;
                    wr_data = in_data;
                    idx_d   = idx_q + (2*L)'(1);
                    if (&idx_q) state_d = CFG;
                end
            end
            CFG: begin
                if (cfg_fire) state_d = ROW_SEND;
            end
            ROW_SEND, COL_SEND: begin
                if (s_fire) begin
                    beat_d = beat_q + L'(1);
                    if (&beat_q) state_d = (state_q == ROW_SEND) ? ROW_RECV : COL_RECV;
                end
            end
            ROW_RECV, COL_RECV: begin
                if (m_fire) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + L'(1);
                    if (fft_m_tlast != (&beat_q)) err_d = 1'b1;
                    if (&beat_q) begin
                        line_d = line_q + L'(1);
                        if (&line_q) state_d = (state_q == ROW_RECV) ? COL_SEND : UNLOAD;
                        else         state_d = (state_q == ROW_RECV) ? ROW_SEND : COL_SEND;
                    end
                end
            end
            UNLOAD: begin
                if (out_fire) begin
                    idx_d = idx_q + (2*L)'(1);
                    if (&idx_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = RST_HOLD;
        endcase
    end

    assign send_d = (state_d == ROW_SEND) || (state_d == COL_SEND);
    assign recv_d = (state_d == ROW_RECV) || (state_d == COL_RECV);

    // Handshake flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RST_HOLD;
            line_q      <= '0;
            beat_q      <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            err_q       <= 1'b0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            aresetn_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            s_valid_q   <= 1'b0;
            s_last_q    <= 1'b0;
            m_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            beat_q      <= beat_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            err_q       <= err_d;
            inv_q       <= inv_d;
            busy_q      <= state_d != IDLE;
            done_q      <= state_d == DONE;
            in_ready_q  <= state_d == LOAD;
            out_valid_q <= state_d == UNLOAD;
            out_last_q  <= (state_d == UNLOAD) && (&idx_d);
            aresetn_q   <= state_d != RST_HOLD;
            cfg_valid_q <= state_d == CFG;
            s_valid_q   <= send_d;
            s_last_q    <= send_d && (&beat_d);
            m_ready_q   <= recv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) buf_q[wr_addr] <= wr_data;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_last       = out_last_q;
    assign out_data       = out_valid_q ? buf_q[idx_q] : '0;
    assign fft_aresetn    = aresetn_q;
    assign fft_cfg_tvalid = cfg_valid_q;
`ifdef FFT2D_INVERSE_EN
    assign fft_cfg_tdata  = {7'b0, ~inv_q};
`else
    assign fft_cfg_tdata  = 8'h01;
`endif
    assign fft_s_tvalid   = s_valid_q;
    assign fft_s_tlast    = s_last_q;
    assign fft_s_tdata    = s_valid_q ? buf_q[line_addr] : '0;
    assign fft_m_tready   = m_ready_q;

endmodule

// File: tb/tb_fft2d_row_col_sched.sv
// Directed bench for fft2d_row_col_sched with a behavioral 1D core (latency 5, optional per-pass offset).
module tb_fft2d_row_col_sched;
    localparam int N   = 8;
    localparam int NN  = 64;
    localparam int LAT = 5;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic        busy, done, err;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid, out_ready = 1'b0, out_last;
    logic [63:0] out_data;
    logic        fft_aresetn;
    logic [7:0]  fft_cfg_tdata;
    logic        fft_cfg_tvalid, fft_cfg_tready = 1'b1;
    logic [63:0] fft_s_tdata;
    logic        fft_s_tvalid, fft_s_tready = 1'b1, fft_s_tlast;
    logic [63:0] fft_m_tdata = '0;
    logic        fft_m_tvalid = 1'b0, fft_m_tready, fft_m_tlast = 1'b0;
`ifdef FFT2D_INVERSE_EN
    logic        inverse = 1'b0;
`endif

    fft2d_row_col_sched #(.N(N), .DW(64)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FFT2D_INVERSE_EN
        .inverse(inverse),
`endif
        .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .fft_aresetn(fft_aresetn),
        .fft_cfg_tdata(fft_cfg_tdata), .fft_cfg_tvalid(fft_cfg_tvalid), .fft_cfg_tready(fft_cfg_tready),
        .fft_s_tdata(fft_s_tdata), .fft_s_tvalid(fft_s_tvalid), .fft_s_tready(fft_s_tready),
        .fft_s_tlast(fft_s_tlast),
        .fft_m_tdata(fft_m_tdata), .fft_m_tvalid(fft_m_tvalid), .fft_m_tready(fft_m_tready),
        .fft_m_tlast(fft_m_tlast)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // core model: settings written only by the main process
    bit add_m = 1'b0, stall_m = 1'b0, inj_m = 1'b0;
    typedef struct { logic [63:0] d; int t; } beat_t;
    beat_t q[$];
    int cyc = 0, sent = 0, rcvd = 0, cfg_n = 0;
    logic [7:0] cfg_d = '0;

    always begin
        logic rstn, sf, mf, cf, sl;
        logic [63:0] sd;
        logic [7:0]  cd;
        @(negedge clk);
        rstn = fft_aresetn;
        sf = fft_s_tvalid && fft_s_tready;
        sd = fft_s_tdata;
        sl = fft_s_tlast;
        mf = fft_m_tvalid && fft_m_tready;
        cf = fft_cfg_tvalid && fft_cfg_tready;
        cd = fft_cfg_tdata;
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            q.delete();
            sent = 0;
            rcvd = 0;
        end else begin
            if (cf) begin cfg_n++; cfg_d = cd; end
            if (mf) begin void'(q.pop_front()); rcvd = (rcvd + 1) % 128; end
            if (sf) begin
                q.push_back('{d: sd + (add_m ? ((sent < NN) ? 64'd1000 : 64'd2000) : 64'd0), t: cyc});
                sent = (sent + 1) % 128;
            end
        end
        #1;
        fft_s_tready   = stall_m ? 1'($urandom_range(0, 1)) : 1'b1;
        fft_cfg_tready = stall_m ? 1'($urandom_range(0, 1)) : 1'b1;
        if (q.size() > 0 && (cyc - q[0].t) >= LAT) begin
            fft_m_tvalid = 1'b1;
            fft_m_tdata  = q[0].d;
            fft_m_tlast  = ((rcvd % N) == N - 1) ^ (inj_m && rcvd == 22);
        end else begin
            fft_m_tvalid = 1'b0;
            fft_m_tdata  = '0;
            fft_m_tlast  = 1'b0;
        end
    end

    int cfg0;

    task automatic start_load(input int base, input bit add_i, input bit stall_i, input bit inj_i, input bit inv_i);
        int t = 0, idx = 0;
        add_m = add_i; stall_m = stall_i; inj_m = inj_i;
        while (busy && t < 400) begin @(negedge clk); t++; end
        chk("idle", 64'(busy), 64'(0));
        cfg0 = cfg_n;
`ifdef FFT2D_INVERSE_EN
        inverse = inv_i;
`endif
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("err_clr", 64'(err), 64'(0));
        chk("busy", 64'(busy), 64'(1));
        @(posedge clk); #1;
        t = 0;
        while (idx < NN && t < 1000) begin
            in_valid = stall_i ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 64'(base + idx);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        chk("load_n", 64'(idx), 64'(NN));
    endtask

    task automatic unload_check(input int base, input bit add_i, input bit stall_i, input bit inj_i, input bit inv_i);
        int t = 0, n = 0, dn = 0, extra = 0;
        bit held = 1'b0;
        logic [63:0] hd = '0;
        logic [7:0]  ecfg = 8'h01;
`ifdef FFT2D_INVERSE_EN
        ecfg = inv_i ? 8'h00 : 8'h01;
`endif
        while (extra < 4 && t < 4000) begin
            out_ready = stall_i ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) dn++;
            if (out_valid) begin
                if (held) chk("hold", out_data, hd);
                if (out_ready) begin
                    chk("out", out_data, 64'(base + n) + (add_i ? 64'd3000 : 64'd0));
                    chk("last", 64'(out_last), 64'(n == NN - 1));
                    n++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = out_data;
                end
            end
            if (n == NN) extra++;
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b0;
        chk("out_n", 64'(n), 64'(NN));
        chk("done_n", 64'(dn), 64'(1));
        chk("err_end", 64'(err), 64'(inj_i));
        chk("cfg_n", 64'(cfg_n - cfg0), 64'(1));
        chk("cfg_d", 64'(cfg_d), 64'(ecfg));
    endtask

    task automatic frame(input int base, input bit add_i, input bit stall_i, input bit inj_i, input bit inv_i);
        start_load(base, add_i, stall_i, inj_i, inv_i);
        unload_check(base, add_i, stall_i, inj_i, inv_i);
    endtask

    initial begin
        int t, n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_aresetn", 64'(fft_aresetn), 64'(0));
        chk("rst_cfg_valid", 64'(fft_cfg_tvalid), 64'(0));
        chk("rst_cfg_data", 64'(fft_cfg_tdata), 64'h01);
        chk("rst_s_valid", 64'(fft_s_tvalid), 64'(0));
        chk("rst_s_last", 64'(fft_s_tlast), 64'(0));
        chk("rst_s_data", fft_s_tdata, 64'(0));
        chk("rst_m_ready", 64'(fft_m_tready), 64'(0));
        rst = 1'b0;

        frame(0,   1'b0, 1'b0, 1'b0, 1'b0);
        frame(100, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(0,   1'b0, 1'b0, 1'b1, 1'b0);
        frame(100, 1'b1, 1'b1, 1'b0, 1'b0);

        // abort a frame during the column pass
        start_load(40, 1'b1, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (rcvd < 70 && t < 2000) begin @(negedge clk); t++; end
        chk("reach_col", 64'(rcvd >= 70), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'(1));
        chk("mid_out_valid", 64'(out_valid), 64'(0));
        chk("mid_m_ready", 64'(fft_m_tready), 64'(0));
        n = 0;
        while (!fft_aresetn && n < 20) begin n++; @(negedge clk); end
        chk("aresetn_low", 64'(n), 64'(4));
        frame(7, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef FFT2D_INVERSE_EN
        frame(0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
